// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer with run control and cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic             AbsJump,
  input  logic [IDX_W-1:0] InstIdx,
  output logic [IDX_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;

  assign LutAddr  = InstIdx;
  assign PC       = r_pc;
  assign CycleCnt = r_cnt;
  assign Running  = (r_state == ST_RUN);
  assign Done     = (r_state == ST_DONE);

  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_state_next = ST_RUN;
          w_pc_next    = '0;
          w_cnt_next   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_next = w_cnt_inc;
        // Halt outranks any branch presented in the same cycle; PC freezes.
        if (Halt) begin
          w_state_next = ST_DONE;
        end else if (BranchEn && Taken) begin
          w_pc_next = AbsJump ? Target : r_pc + Target;
        end else begin
          w_pc_next = r_pc + PC_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Halt = 1'b0;
  logic       BranchEn = 1'b0;
  logic       Taken = 1'b0;
  logic       AbsJump = 1'b0;
  logic [4:0] InstIdx = 5'd0;
  logic [4:0] LutAddr;
  logic [9:0] Target = 10'd0;
  logic [9:0] PC;
  logic       Running;
  logic       Done;
  logic [15:0] CycleCnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: mode 0=idle, 1=run, 2=done
  int m_mode = 0;
  int m_pc = 0;
  int m_cnt = 0;

  pc_sequencer #(.PC_W(10), .IDX_W(5), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .BranchEn(BranchEn), .Taken(Taken), .AbsJump(AbsJump),
    .InstIdx(InstIdx), .LutAddr(LutAddr), .Target(Target),
    .PC(PC), .Running(Running), .Done(Done), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0;
    end else if (m_mode == 1) begin
      m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      if (Halt) m_mode = 2;
      else if (BranchEn && Taken)
        m_pc = AbsJump ? int'(Target) : (m_pc + int'(Target)) % 1024;
      else m_pc = (m_pc + 1) % 1024;
    end else if (Start) begin
      m_mode = 1; m_pc = 0; m_cnt = 0;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc_pc", int'(PC), m_pc);
      chk("cyc_cnt", int'(CycleCnt), m_cnt);
      chk("cyc_running", int'(Running), int'(m_mode == 1));
      chk("cyc_done", int'(Done), int'(m_mode == 2));
      chk("cyc_lutaddr", int'(LutAddr), int'(InstIdx));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic branch(input bit abs_j, input bit tk, input int tgt);
    BranchEn = 1'b1; Taken = tk; AbsJump = abs_j; Target = 10'(tgt);
    step();
    BranchEn = 1'b0; Taken = 1'b0; AbsJump = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    chk("rst_pc", int'(PC), 0);
    chk("rst_running", int'(Running), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_cnt", int'(CycleCnt), 0);
    Reset = 1'b0;

    Start = 1'b1; step(); Start = 1'b0;
    chk("start_pc", int'(PC), 0);
    chk("start_running", int'(Running), 1);
    for (int i = 1; i <= 5; i++) begin
      InstIdx = 5'(i * 7);
      step();
      chk("seq_pc", int'(PC), i);
    end
    chk("seq_cnt", int'(CycleCnt), 5);

    step(); step();
    chk("pc_at7", int'(PC), 7);
    branch(1'b1, 1'b1, 'h155);
    chk("abs_taken", int'(PC), 'h155);
    branch(1'b1, 1'b1, 7);
    branch(1'b1, 1'b0, 'h155);
    chk("abs_not_taken", int'(PC), 8);

    branch(1'b1, 1'b1, 1020);
    branch(1'b0, 1'b1, 6);
    chk("rel_wrap", int'(PC), 2);
    branch(1'b1, 1'b1, 20);
    branch(1'b0, 1'b1, 'h3FC);
    chk("rel_backward", int'(PC), 16);

    branch(1'b1, 1'b1, 30);
    Halt = 1'b1;
    branch(1'b1, 1'b1, 'h155);
    Halt = 1'b0;
    chk("halt_done", int'(Done), 1);
    chk("halt_running", int'(Running), 0);
    chk("halt_pc", int'(PC), 30);
    step();
    chk("done_hold_pc", int'(PC), 30);
    Start = 1'b1; step(); Start = 1'b0;
    chk("restart_pc", int'(PC), 0);
    chk("restart_cnt", int'(CycleCnt), 0);
    chk("restart_running", int'(Running), 1);
    chk("restart_done", int'(Done), 0);

    branch(1'b1, 1'b1, 50);
    chk("pc_at50", int'(PC), 50);
    Reset = 1'b1; Start = 1'b1; Halt = 1'b1;
    branch(1'b0, 1'b1, 3);
    Reset = 1'b0; Start = 1'b0; Halt = 1'b0;
    chk("midrst_pc", int'(PC), 0);
    chk("midrst_cnt", int'(CycleCnt), 0);
    chk("midrst_running", int'(Running), 0);
    chk("midrst_done", int'(Done), 0);
    step();
    chk("midrst_stays_idle", int'(Running), 0);

    InstIdx = 5'b10110;
    #1 chk("lut_idle", int'(LutAddr), 'b10110);
    Start = 1'b1; step(); Start = 1'b0;
    chk("lut_run", int'(LutAddr), 'b10110);
    Halt = 1'b1; step(); Halt = 1'b0;
    chk("lut_done", int'(LutAddr), 'b10110);

    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      InstIdx = 5'(i);
      step();
    end
    chk("sat_cnt", int'(CycleCnt), 'hFFFF);
    step();
    chk("sat_hold", int'(CycleCnt), 'hFFFF);
    chk("sat_running", int'(Running), 1);

    @(negedge Clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
